i2c_sample_sequencer: RTL and testbench
=======================================

// Module: i2c_sample_sequencer
// PURPOSE
//  Upstream controller for the single-byte I2C read master: periodically issues N_BYTES
//  consecutive register reads (BASE_REG, BASE_REG+1, ...) to one device, collects the bytes,
//  presents the assembled sample on a valid/ready port; retries NACK/timeout, counts failures.
//  Sits between the I2C read master (cmd/rd ports) and the sample consumer (smp ports).
// PARAMETERS
//  DEV_ADDR    7'h29  7-bit slave address driven on cmd_dev
//  BASE_REG    8'h77  first register read per sample
//  N_BYTES     2      bytes per sample, 1..4
//  PERIOD      1000   i2c_clk cycles in S_WAIT between samples, >=2
//  TIMEOUT     64     i2c_clk cycles allowed from command accept to rd_done, >=2
//  MAX_RETRY   2      retries per byte before sample is abandoned
// PORTS
//  i2c_clk    in   1          clock
//  reset      in   1          synchronous, active-high
//  enable     in   1          run sampling loop
//  cmd_valid  out  1          read request to master
//  cmd_ready  in   1          master idle, accepts request
//  cmd_dev    out  7          = DEV_ADDR, constant
//  cmd_reg    out  8          register address of current byte
//  rd_done    in   1          1-cycle pulse: read finished
//  rd_nack    in   1          valid with rd_done: slave NACKed
//  rd_data    in   8          valid with rd_done && !rd_nack
//  smp_valid  out  1          sample available
//  smp_ready  in   1          consumer accepts sample
//  smp_data   out  8*N_BYTES  sample, byte 0 (BASE_REG) in MSBs
//  err_pulse  out  1          1-cycle pulse: sample abandoned
//  err_count  out  8          abandoned samples, saturates at 8'hFF
//  busy       out  1          high in S_CMD/S_RESP
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, byte_idx/retry/counters 0; dominates all events,
//   mid-transaction included (cmd_valid low after that edge; late rd_done ignored).
//  S_IDLE: enable=1 -> S_WAIT, period counter <= PERIOD-1.
//  S_WAIT: decrement; at 0 -> S_CMD, byte_idx<=0, retry<=0. enable=0 -> S_IDLE.
//  S_CMD: cmd_valid=1, cmd_reg=BASE_REG+byte_idx (8-bit wrap: 8'hFF+1=8'h00); cmd_valid stays
//   high, cmd_reg stable, until cmd_ready. On cmd_valid&&cmd_ready -> S_RESP, cmd_valid low
//   next cycle, timeout counter <= TIMEOUT-1. enable ignored from S_CMD to sample end.
//  S_RESP: rd_done&&!rd_nack -> write rd_data to byte slot byte_idx; last byte -> S_OUT,
//   else byte_idx++ -> S_CMD. rd_nack, or counter at 0 without rd_done -> failure.
//   rd_done in same cycle as timeout expiry: rd_done wins.
//  Failure: retry<MAX_RETRY -> retry++, S_CMD same byte; else err_pulse=1 one cycle,
//   err_count++ (sat), partial bytes discarded, -> S_WAIT (reload PERIOD-1).
//  retry resets to 0 on each successful byte.
//  S_OUT: smp_valid=1; smp_data loaded only on entry to S_OUT, otherwise holds last sample.
//   smp_valid&&smp_ready -> smp_valid low next cycle; -> S_WAIT if enable else S_IDLE.
//   No timeout in S_OUT: backpressure stalls sampling indefinitely.
//  rd_done outside S_RESP ignored. Period timed from sample end, not free-running.
//  Min latency enable->smp_valid: 1+PERIOD+N_BYTES*(1+read latency) cycles.
// STRUCTURE
//  i2c_pkg: state localparams (S_IDLE..S_OUT), default DEV_ADDR/BASE_REG.
//  Sub-module i2c_down_counter (load, load_val, en, zero): instanced twice (period, timeout).
//  Byte buffer and FSM in this module.
// TESTING
//  PERIOD=4, N_BYTES=2, model returns 8'hAB, 8'hCD -> cmd_reg 8'h77 then 8'h78; smp_data=16'hABCD.
//  cmd_ready low 5 cycles in S_CMD -> cmd_valid and cmd_reg held 5 cycles, one accept only.
//  Byte 1 NACK twice then ack 8'h11 -> 3 requests to 8'h78, no err_pulse, smp_data[7:0]=8'h11.
//  Never assert rd_done, MAX_RETRY=2 -> 3 timeouts of TIMEOUT cycles, err_pulse 1 cycle, err_count=1.
//  smp_ready low 20 cycles -> smp_valid/smp_data stable, no new cmd_valid; enable=0 then -> S_IDLE.
//  BASE_REG=8'hFF, N_BYTES=2 -> cmd_reg 8'hFF, 8'h00; reset in S_RESP -> all outputs 0 next edge.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C sample sequencer.
// Sequencer states and default device/register addresses.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CMD,
        S_RESP,
        S_OUT
    } state_t;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h29;
    localparam logic [7:0] DEF_BASE_REG = 8'h77;

endpackage

// File: rtl/i2c_down_counter.sv
// Loadable down counter that stops at zero.
// Used for the sample period and the read timeout.
module i2c_down_counter #(
    parameter int W = 8
) (
    input  logic         i2c_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/i2c_sample_sequencer.sv
// Periodic multi-byte register sampler on top of a single-byte I2C read master.
// Retries failed reads, abandons a sample after too many, counts abandons.
module i2c_sample_sequencer
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter logic [7:0] BASE_REG  = DEF_BASE_REG,
    parameter int         N_BYTES   = 2,
    parameter int         PERIOD    = 1000,
    parameter int         TIMEOUT   = 64,
    parameter int         MAX_RETRY = 2
) (
    input  logic                 i2c_clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [6:0]           cmd_dev,
    output logic [7:0]           cmd_reg,
    input  logic                 rd_done,
    input  logic                 rd_nack,
    input  logic [7:0]           rd_data,
    output logic                 smp_valid,
    input  logic                 smp_ready,
    output logic [8*N_BYTES-1:0] smp_data,
    output logic                 err_pulse,
    output logic [7:0]           err_count,
    output logic                 busy
);

    localparam int SW = 8 * N_BYTES;
    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    byte_idx;
    logic [1:0]    byte_idx_nxt;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_nxt;
    logic [SW-1:0] sbuf;
    logic [SW-1:0] sbuf_nxt;
    logic          load_smp;
    logic          err_nxt;
    logic [7:0]    err_count_nxt;

    logic per_load;
    logic per_zero;
    logic to_load;
    logic to_zero;

    i2c_down_counter #(.W(PW)) u_period (
        .i2c_clk  (i2c_clk),
        .reset    (reset),
        .load     (per_load),
        .load_val (PW'(PERIOD - 1)),
        .en       (state == S_WAIT),
        .zero     (per_zero)
    );

    i2c_down_counter #(.W(TW)) u_timeout (
        .i2c_clk  (i2c_clk),
        .reset    (reset),
        .load     (to_load),
        .load_val (TW'(TIMEOUT - 1)),
        .en       (state == S_RESP),
        .zero     (to_zero)
    );

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            byte_idx  <= '0;
            retry     <= '0;
            sbuf      <= '0;
            smp_data  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            byte_idx  <= byte_idx_nxt;
            retry     <= retry_nxt;
            sbuf      <= sbuf_nxt;
            err_pulse <= err_nxt;
            err_count <= err_count_nxt;
            if (load_smp) begin
                smp_data <= sbuf_nxt;
            end
        end
    end

    // A read that completes on the timeout cycle still counts as success.
    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        retry_nxt    = retry;
        sbuf_nxt     = sbuf;
        load_smp     = 1'b0;
        err_nxt      = 1'b0;
        per_load     = 1'b0;
        to_load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_WAIT;
                    per_load  = 1'b1;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (per_zero) begin
                    state_nxt    = S_CMD;
                    byte_idx_nxt = '0;
                    retry_nxt    = '0;
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_nxt = S_RESP;
                    to_load   = 1'b1;
                end
            end
            S_RESP: begin
                if (rd_done && !rd_nack) begin
                    for (int i = 0; i < N_BYTES; i++) begin
                        if (byte_idx == 2'(i)) begin
                            sbuf_nxt[8*(N_BYTES-1-i) +: 8] = rd_data;
                        end
                    end
                    retry_nxt = '0;
                    if (byte_idx == 2'(N_BYTES - 1)) begin
                        state_nxt = S_OUT;
                        load_smp  = 1'b1;
                    end else begin
                        state_nxt    = S_CMD;
                        byte_idx_nxt = byte_idx + 2'd1;
                    end
                end else if (rd_done || to_zero) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        state_nxt = S_CMD;
                        retry_nxt = retry + RW'(1);
                    end else begin
                        state_nxt = S_WAIT;
                        per_load  = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (smp_ready) begin
                    state_nxt = enable ? S_WAIT : S_IDLE;
                    per_load  = enable;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign err_count_nxt = (err_nxt && err_count != 8'hFF)
                         ? err_count + 8'd1 : err_count;

    assign cmd_valid = (state == S_CMD);
    assign cmd_dev   = DEV_ADDR;
    assign cmd_reg   = cmd_valid ? BASE_REG + {6'd0, byte_idx} : 8'h00;
    assign smp_valid = (state == S_OUT);
    assign busy      = (state == S_CMD) || (state == S_RESP);

endmodule

// File: tb/tb_i2c_sample_sequencer.sv
// Scoreboard bench for i2c_sample_sequencer with a transaction-level model.
// A read-master responder replays planned responses; monitors check outputs.
module tb_i2c_sample_sequencer;

    localparam int NB = 2;
    localparam int PER = 4;
    localparam int TO = 8;
    localparam int MR = 2;
    localparam logic [7:0] BASE = 8'hFF;
    localparam logic [6:0] DEV = 7'h29;
    localparam int K_ACK = 0;
    localparam int K_NACK = 1;
    localparam int K_NONE = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         lat;
        int         stall;
    } resp_t;

    typedef struct {
        logic [7:0] addr;
        int         gap;
    } cexp_t;

    logic        i2c_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        rd_done = 1'b0;
    logic        rd_nack = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        smp_ready = 1'b0;
    logic        cmd_valid;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic        busy;

    i2c_sample_sequencer #(
        .DEV_ADDR  (DEV),
        .BASE_REG  (BASE),
        .N_BYTES   (NB),
        .PERIOD    (PER),
        .TIMEOUT   (TO),
        .MAX_RETRY (MR)
    ) dut (
        .i2c_clk   (i2c_clk),
        .reset     (reset),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dev   (cmd_dev),
        .cmd_reg   (cmd_reg),
        .rd_done   (rd_done),
        .rd_nack   (rd_nack),
        .rd_data   (rd_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 i2c_clk = ~i2c_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_model = 0;
    int cyc = 0;
    bit drv_on = 0;
    bit mon_on = 0;
    bit waiting = 0;

    resp_t       resp_q[$];
    cexp_t       exp_cmd[$];
    logic [15:0] exp_smp[$];
    logic [7:0]  exp_err[$];
    int          sstall_q[$];

    task automatic check(input bit ok, input string name,
                         input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic resp_t mk(input int kind, input logic [7:0] data,
                                 input int lat, input int stall);
        resp_t r;
        r.kind = kind;
        r.data = data;
        r.lat = lat;
        r.stall = stall;
        return r;
    endfunction

    // Reference: walk one sample's responses in order and derive what the
    // sequencer must request, deliver, or report.
    task automatic run_sample(input resp_t rl[$], input int sstall);
        logic [15:0] s;
        logic [7:0]  a;
        cexp_t       c;
        int          b;
        int          fails;
        bit          prev_none;
        s = '0;
        b = 0;
        fails = 0;
        prev_none = 0;
        foreach (rl[k]) begin
            a = BASE + 8'(b);
            c.addr = a;
            c.gap = prev_none ? TO + 1 + rl[k].stall : -1;
            exp_cmd.push_back(c);
            resp_q.push_back(rl[k]);
            if (rl[k].kind == K_ACK) begin
                s[8*(NB-1-b) +: 8] = rl[k].data;
                b++;
                fails = 0;
                prev_none = 0;
            end else begin
                prev_none = (rl[k].kind == K_NONE);
                fails++;
                if (fails > MR) begin
                    err_model = (err_model < 255) ? err_model + 1 : 255;
                    exp_err.push_back(8'(err_model));
                    return;
                end
            end
        end
        if (b == NB) begin
            exp_smp.push_back(s);
            sstall_q.push_back(sstall);
        end
    endtask

    task automatic gen_random(input int mode);
        resp_t l[$];
        bit    dead;
        bit    got;
        int    f;
        int    r;
        int    kd;
        int    st;
        dead = 0;
        for (int b = 0; b < NB && !dead; b++) begin
            f = 0;
            got = 0;
            while (!got && !dead) begin
                r = int'($urandom_range(0, 9));
                if (mode == 1) kd = K_NACK;
                else kd = (r < 6) ? K_ACK : (r < 8) ? K_NACK : K_NONE;
                st = (mode == 1) ? 0 : int'($urandom_range(0, 3));
                l.push_back(mk(kd, 8'($urandom), int'($urandom_range(1, TO)), st));
                if (kd == K_ACK) got = 1;
                else begin
                    f++;
                    if (f > MR) dead = 1;
                end
            end
        end
        run_sample(l, (mode == 1) ? 0 : int'($urandom_range(0, 4)));
    endtask

    // Read-master and consumer responder, driven just after each rising edge.
    initial begin : drv
        int    cnt;
        int    scnt;
        int    cstall;
        bit    s_armed;
        resp_t cur;
        cnt = 0;
        scnt = 0;
        cstall = -1;
        s_armed = 0;
        forever begin
            @(posedge i2c_clk);
            #1;
            cmd_ready = 1'b0;
            rd_done = 1'b0;
            rd_nack = 1'b0;
            smp_ready = 1'b0;
            if (drv_on) begin
                if (waiting) begin
                    cnt--;
                    if (cnt <= 0) begin
                        waiting = 0;
                        rd_done = 1'b1;
                        rd_nack = (cur.kind == K_NACK);
                        rd_data = cur.data;
                    end
                end else if (cmd_valid) begin
                    if (resp_q.size() > 0) begin
                        if (cstall < 0) cstall = resp_q[0].stall;
                        if (cstall > 0) cstall--;
                        else begin
                            cur = resp_q.pop_front();
                            cstall = -1;
                            cmd_ready = 1'b1;
                            if (cur.kind != K_NONE) begin
                                waiting = 1;
                                cnt = cur.lat;
                            end
                        end
                    end
                end else if (!busy && $urandom_range(0, 5) == 0) begin
                    rd_done = 1'b1;
                    rd_nack = 1'($urandom);
                    rd_data = 8'($urandom);
                end
                if (smp_valid) begin
                    if (!s_armed) begin
                        s_armed = 1;
                        scnt = (sstall_q.size() > 0) ? sstall_q.pop_front() : 0;
                    end
                    if (scnt > 0) scnt--;
                    else begin
                        smp_ready = 1'b1;
                        s_armed = 0;
                    end
                end
            end
        end
    end

    // Monitor on the falling edge: all signals are stable here.
    initial begin : mon
        bit          pv_cmd;
        bit          pv_smp;
        logic [7:0]  p_reg;
        logic [15:0] p_smp;
        int          last_acc;
        cexp_t       c;
        logic [15:0] es;
        logic [7:0]  ee;
        pv_cmd = 0;
        pv_smp = 0;
        p_reg = '0;
        p_smp = '0;
        last_acc = 0;
        forever begin
            @(negedge i2c_clk);
            cyc++;
            if (mon_on) begin
                if (pv_cmd)
                    check(cmd_valid && cmd_reg == p_reg, "cmd_hold",
                          {cmd_valid, cmd_reg}, {1'b1, p_reg});
                if (cmd_valid && cmd_ready) begin
                    check(cmd_dev == DEV, "cmd_dev", cmd_dev, DEV);
                    if (exp_cmd.size() == 0) begin
                        check(0, "cmd_unexpected", cmd_reg, 0);
                    end else begin
                        c = exp_cmd.pop_front();
                        check(cmd_reg == c.addr, "cmd_reg", cmd_reg, c.addr);
                        if (c.gap >= 0)
                            check(cyc - last_acc == c.gap, "retry_gap",
                                  cyc - last_acc, c.gap);
                    end
                    last_acc = cyc;
                end
                if (pv_smp)
                    check(smp_valid && smp_data == p_smp && !cmd_valid,
                          "smp_hold", {cmd_valid, smp_valid, smp_data},
                          {1'b0, 1'b1, p_smp});
                if (smp_valid && smp_ready) begin
                    if (exp_smp.size() == 0) begin
                        check(0, "smp_unexpected", smp_data, 0);
                    end else begin
                        es = exp_smp.pop_front();
                        check(smp_data == es, "smp_data", smp_data, es);
                    end
                end
                if (err_pulse) begin
                    if (exp_err.size() == 0) begin
                        check(0, "err_unexpected", err_count, 0);
                    end else begin
                        ee = exp_err.pop_front();
                        check(err_count == ee, "err_count", err_count, ee);
                    end
                end
            end
            pv_cmd = cmd_valid && !cmd_ready;
            p_reg = cmd_reg;
            pv_smp = smp_valid && !smp_ready;
            p_smp = smp_data;
        end
    end

    task automatic idle_check(input string name);
        int seen;
        seen = 0;
        repeat (12) begin
            @(negedge i2c_clk);
            if (cmd_valid || busy || smp_valid) seen++;
        end
        check(seen == 0, name, seen, 0);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_cmd.size() + exp_smp.size() + exp_err.size()) > 0
               && t < 20000) begin
            @(negedge i2c_clk);
            t++;
        end
        check(t < 20000, name, t, 20000);
        enable = 1'b0;
        exp_cmd.delete();
        exp_smp.delete();
        exp_err.delete();
        idle_check({name, "_idle"});
    endtask

    initial begin : main
        resp_t l[$];
        int    t;
        repeat (3) @(negedge i2c_clk);
        check(cmd_valid == 0, "rst_cmd_valid", cmd_valid, 0);
        check(cmd_reg == 0, "rst_cmd_reg", cmd_reg, 0);
        check(smp_valid == 0, "rst_smp_valid", smp_valid, 0);
        check(smp_data == 0, "rst_smp_data", smp_data, 0);
        check(err_pulse == 0, "rst_err_pulse", err_pulse, 0);
        check(err_count == 0, "rst_err_count", err_count, 0);
        check(busy == 0, "rst_busy", busy, 0);
        check(cmd_dev == DEV, "rst_cmd_dev", cmd_dev, DEV);
        reset = 1'b0;
        mon_on = 1;
        drv_on = 1;

        l = {};
        l.push_back(mk(K_ACK, 8'hAB, 2, 0));
        l.push_back(mk(K_ACK, 8'hCD, 3, 0));
        run_sample(l, 0);
        l = {};
        l.push_back(mk(K_ACK, 8'h12, 1, 5));
        l.push_back(mk(K_ACK, 8'h34, TO, 0));
        run_sample(l, 0);
        l = {};
        l.push_back(mk(K_ACK, 8'h5A, 1, 0));
        l.push_back(mk(K_NACK, 8'h00, 2, 0));
        l.push_back(mk(K_NACK, 8'h00, 1, 0));
        l.push_back(mk(K_ACK, 8'h11, 4, 0));
        run_sample(l, 0);
        l = {};
        l.push_back(mk(K_NONE, 8'h00, 1, 0));
        l.push_back(mk(K_NONE, 8'h00, 1, 0));
        l.push_back(mk(K_NONE, 8'h00, 1, 0));
        run_sample(l, 0);
        l = {};
        l.push_back(mk(K_ACK, 8'h77, 2, 0));
        l.push_back(mk(K_ACK, 8'h88, 2, 0));
        run_sample(l, 20);
        enable = 1'b1;
        drain("directed");

        for (int i = 0; i < 40; i++) gen_random(0);
        enable = 1'b1;
        drain("random");

        for (int i = 0; i < 260; i++) gen_random(1);
        enable = 1'b1;
        drain("saturate");
        check(err_count == 8'hFF, "err_sat", err_count, 8'hFF);

        begin
            cexp_t c;
            c.addr = BASE;
            c.gap = -1;
            exp_cmd.push_back(c);
            resp_q.push_back(mk(K_ACK, 8'h99, TO, 0));
        end
        enable = 1'b1;
        t = 0;
        while (!(busy && !cmd_valid) && t < 100) begin
            @(negedge i2c_clk);
            t++;
        end
        check(t < 100, "reach_resp", t, 100);
        reset = 1'b1;
        drv_on = 0;
        enable = 1'b0;
        @(negedge i2c_clk);
        check({cmd_valid, busy, smp_valid, err_pulse} == 4'b0, "rst_mid_ctrl",
              {cmd_valid, busy, smp_valid, err_pulse}, 0);
        check(cmd_reg == 0, "rst_mid_cmd_reg", cmd_reg, 0);
        check(smp_data == 0, "rst_mid_smp_data", smp_data, 0);
        check(err_count == 0, "rst_mid_err_count", err_count, 0);
        reset = 1'b0;
        waiting = 0;
        resp_q.delete();
        exp_cmd.delete();
        sstall_q.delete();
        err_model = 0;
        rd_done = 1'b1;
        rd_nack = 1'b0;
        rd_data = 8'h99;
        idle_check("late_rd_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
